// File: rtl/lcd_pkg.sv
//------------------------------------------------------------------------------
// lcd_pkg : shared constants, FSM state type and DDRAM address stepping
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;
  localparam logic [3:0] NIB_FUNC_4BIT = 4'h2;
  localparam logic [6:0] LINE0_END     = 7'h27;
  localparam logic [6:0] LINE1_BASE    = 7'h40;
  localparam logic [6:0] LINE1_END     = 7'h67;

  typedef enum logic [1:0] {
    ST_IDLE8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } lcd_state_e;

  // Next DDRAM address after a character write; the hole between lines jumps to line 1.
  function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
    if (inc) begin
      if (addr >= LINE1_END) return 7'h00;
      if (addr >= LINE0_END && addr < LINE1_BASE) return LINE1_BASE;
      return addr + 7'd1;
    end
    if (addr == 7'h00) return LINE1_END;
    if (addr == LINE1_BASE) return LINE0_END;
    return addr - 7'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_strobe_sync.sv
//------------------------------------------------------------------------------
// lcd_strobe_sync : synchronises LCD_E/LCD_D, holds the last D seen with E high
//                   and flags the falling edge of the synchronised strobe
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LCD_E,
  input  logic [4:0] LCD_D,
  output logic       fall,
  output logic [4:0] nib_rs
);

  logic [5:0] r_sync [SYNC_STAGES];
  logic       r_e_prev;
  logic [4:0] r_hold;
  logic       w_e_synced;

  assign w_e_synced = r_sync[SYNC_STAGES-1][5];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_e_prev <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_sync[0] <= {LCD_E, LCD_D};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_prev <= w_e_synced;
      // The nibble is captured while E is high so post-fall bus changes are ignored.
      if (w_e_synced) r_hold <= r_sync[SYNC_STAGES-1][4:0];
    end
  end

  assign fall   = r_e_prev & ~w_e_synced;
  assign nib_rs = r_hold;

endmodule

`default_nettype wire

// File: rtl/lcd_bus_decoder.sv
//------------------------------------------------------------------------------
// lcd_bus_decoder : passive HD44780 4-bit bus receiver; reassembles bytes,
//                   decodes cursor commands and emits character writes
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int NIBBLE_TIMEOUT = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LCD_E,
  input  logic [4:0] LCD_D,
  output logic       BYTE_VALID,
  output logic [7:0] BYTE,
  output logic       BYTE_RS,
  output logic       CHAR_WE,
  output logic [6:0] CHAR_ADDR,
  output logic [7:0] CHAR_DATA,
  output logic [6:0] CURSOR,
  output logic       MODE_4BIT,
  output logic       ERR
);

  localparam int c_TIMER_W = $clog2(NIBBLE_TIMEOUT + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMEOUT = c_TIMER_W'(NIBBLE_TIMEOUT);

  logic                 w_fall;
  logic [4:0]           w_nib_rs;
  logic                 w_rs;
  logic [3:0]           w_nib;
  lcd_state_e           r_state;
  logic [3:0]           r_hi_nib;
  logic                 r_hi_rs;
  logic [c_TIMER_W-1:0] r_timer;
  logic                 r_dir_inc;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .LCD_E  (LCD_E),
    .LCD_D  (LCD_D),
    .fall   (w_fall),
    .nib_rs (w_nib_rs)
  );

  assign w_rs  = w_nib_rs[4];
  assign w_nib = w_nib_rs[3:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE8;
      r_hi_nib   <= '0;
      r_hi_rs    <= 1'b0;
      r_timer    <= '0;
      BYTE_VALID <= 1'b0;
      BYTE       <= '0;
      BYTE_RS    <= 1'b0;
      MODE_4BIT  <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      BYTE_VALID <= 1'b0;
      case (r_state)
        ST_IDLE8: if (w_fall) begin
          BYTE_VALID <= 1'b1;
          BYTE       <= {w_nib, 4'h0};
          BYTE_RS    <= w_rs;
          if (!w_rs && w_nib == NIB_FUNC_4BIT) begin
            MODE_4BIT <= 1'b1;
            r_state   <= ST_HI;
          end
        end
        ST_HI: if (w_fall) begin
          r_hi_nib <= w_nib;
          r_hi_rs  <= w_rs;
          r_timer  <= '0;
          r_state  <= ST_LO;
        end
        ST_LO: begin
          if (w_fall) begin
            if (w_rs == r_hi_rs) begin
              BYTE_VALID <= 1'b1;
              BYTE       <= {r_hi_nib, w_nib};
              BYTE_RS    <= w_rs;
              r_state    <= ST_HI;
            end else begin
              // RS mismatch: resynchronise on this nibble as a fresh high half.
              ERR      <= 1'b1;
              r_hi_nib <= w_nib;
              r_hi_rs  <= w_rs;
              r_timer  <= '0;
            end
          end else if (r_timer == c_TIMEOUT) begin
            ERR     <= 1'b1;
            r_state <= ST_HI;
          end else begin
            r_timer <= r_timer + c_TIMER_W'(1);
          end
        end
        default: r_state <= ST_IDLE8;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CURSOR    <= '0;
      r_dir_inc <= 1'b1;
    end else if (BYTE_VALID) begin
      if (BYTE_RS) begin
        CURSOR <= step_addr(CURSOR, r_dir_inc);
      end else if (BYTE == CMD_CLEAR) begin
        CURSOR    <= '0;
        r_dir_inc <= 1'b1;
      end else if (BYTE[7:1] == CMD_HOME[7:1]) begin
        CURSOR <= '0;
      end else if (BYTE[7:2] == CMD_ENTRY[7:2]) begin
        r_dir_inc <= BYTE[1];
      end else if ((BYTE & CMD_DDRAM) != 8'h00) begin
        CURSOR <= BYTE[6:0];
      end
    end
  end

  assign CHAR_WE   = BYTE_VALID & BYTE_RS;
  assign CHAR_ADDR = CURSOR;
  assign CHAR_DATA = BYTE;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_decoder.sv
//------------------------------------------------------------------------------
// tb_lcd_bus_decoder : directed bench with a transfer-level reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_bus_decoder;

  localparam int c_TIMEOUT = 40;
  localparam int c_SYNC    = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       LCD_E = 1'b0;
  logic [4:0] LCD_D = '0;
  logic       BYTE_VALID, BYTE_RS, CHAR_WE, MODE_4BIT, ERR;
  logic [7:0] BYTE, CHAR_DATA;
  logic [6:0] CHAR_ADDR, CURSOR;

  lcd_bus_decoder #(.NIBBLE_TIMEOUT(c_TIMEOUT), .SYNC_STAGES(c_SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .LCD_E(LCD_E), .LCD_D(LCD_D),
    .BYTE_VALID(BYTE_VALID), .BYTE(BYTE), .BYTE_RS(BYTE_RS),
    .CHAR_WE(CHAR_WE), .CHAR_ADDR(CHAR_ADDR), .CHAR_DATA(CHAR_DATA),
    .CURSOR(CURSOR), .MODE_4BIT(MODE_4BIT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int last_fall_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       rs;
    logic [6:0] addr;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, in terms of transfers rather than bus cycles
  bit       m_mode4, m_have_hi, m_hi_rs, m_inc, m_err;
  bit [3:0] m_hi_nib;
  bit [6:0] m_cursor;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Two display lines of 40 columns laid end to end as positions 0..79.
  function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
    int pos;
    if (inc && a >= 7'h28 && a < 7'h40) return 7'h40;
    pos = (a >= 7'h40) ? 40 + int'(a) - 64 : int'(a);
    pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
    return (pos >= 40) ? 7'(pos - 40 + 64) : 7'(pos);
  endfunction

  task automatic m_emit(input logic [7:0] b, input bit rs);
    exp_t e;
    e.b = b; e.rs = rs; e.addr = m_cursor;
    exp_q.push_back(e);
    if (rs) m_cursor = m_step(m_cursor, m_inc);
    else if (b == 8'h01) begin m_cursor = 0; m_inc = 1; end
    else if (b == 8'h02 || b == 8'h03) m_cursor = 0;
    else if (b >= 8'h04 && b <= 8'h07) m_inc = b[1];
    else if (b >= 8'h80) m_cursor = 7'(b - 8'h80);
  endtask

  task automatic m_fall(input bit rs, input bit [3:0] nib);
    if (!m_mode4) begin
      m_emit({nib, 4'h0}, rs);
      if (!rs && nib == 4'h2) m_mode4 = 1;
    end else if (!m_have_hi) begin
      m_have_hi = 1; m_hi_rs = rs; m_hi_nib = nib;
    end else if (rs == m_hi_rs) begin
      m_emit({m_hi_nib, nib}, rs);
      m_have_hi = 0;
    end else begin
      m_err = 1; m_hi_rs = rs; m_hi_nib = nib;
    end
  endtask

  task automatic m_timeout();
    if (m_mode4 && m_have_hi) begin m_err = 1; m_have_hi = 0; end
  endtask

  task automatic m_reset();
    m_mode4 = 0; m_have_hi = 0; m_hi_rs = 0; m_hi_nib = 0;
    m_cursor = 0; m_inc = 1; m_err = 0;
    exp_q.delete();
  endtask

  // Compare process: every completed transfer is checked against the model queue.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (BYTE_VALID) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte_valid", {24'h0, BYTE}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("byte", BYTE, e.b);
          chk("byte_rs", BYTE_RS, e.rs);
          chk("char_we", CHAR_WE, e.rs);
          chk("latency", cyc - last_fall_cyc, c_SYNC + 1);
          if (e.rs) begin
            chk("char_addr", CHAR_ADDR, e.addr);
            chk("char_data", CHAR_DATA, e.b);
          end
        end
      end else begin
        chk("char_we_idle", CHAR_WE, 0);
      end
    end
  end

  task automatic send_nibble(input bit rs, input bit [3:0] nib);
    @(posedge CLK); #1;
    LCD_D = {rs, nib};
    LCD_E = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    LCD_E = 1'b0;
    LCD_D = ~{rs, nib};
    last_fall_cyc = cyc;
    m_fall(rs, nib);
    repeat (6) @(posedge CLK);
  endtask

  task automatic send_byte(input bit rs, input bit [7:0] b);
    send_nibble(rs, b[7:4]);
    send_nibble(rs, b[3:0]);
  endtask

  task automatic check_state(input string tag);
    @(negedge CLK);
    chk({tag, "_cursor"}, CURSOR, m_cursor);
    chk({tag, "_mode4"}, MODE_4BIT, m_mode4);
    chk({tag, "_err"}, ERR, m_err);
  endtask

  initial begin
    m_reset();
    #22;
    chk("rst_valid", BYTE_VALID, 0);
    chk("rst_cursor", CURSOR, 0);
    chk("rst_mode4", MODE_4BIT, 0);
    chk("rst_err", ERR, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Init sequence in 8-bit mode, then switch to 4-bit
    send_nibble(0, 4'h3); send_nibble(0, 4'h3); send_nibble(0, 4'h3); send_nibble(0, 4'h2);
    send_byte(0, 8'h28); send_byte(0, 8'h0C);
    check_state("init");
    chk("init_mode4_lit", MODE_4BIT, 1);

    send_byte(0, 8'h80); send_byte(1, 8'h61); send_byte(1, 8'h62);
    check_state("ab");
    chk("ab_cursor_lit", CURSOR, 7'h02);

    // Line wraps and the inter-line hole
    send_byte(0, 8'hA7); send_byte(1, 8'h78);
    check_state("wrap0"); chk("wrap0_lit", CURSOR, 7'h40);
    send_byte(0, 8'hE7); send_byte(1, 8'h79);
    check_state("wrap1"); chk("wrap1_lit", CURSOR, 7'h00);
    send_byte(0, 8'hB0); send_byte(1, 8'h77);
    check_state("hole"); chk("hole_lit", CURSOR, 7'h40);

    // Decrement mode, clear, home
    send_byte(0, 8'h04); send_byte(0, 8'h80); send_byte(1, 8'h7A);
    check_state("dec"); chk("dec_lit", CURSOR, 7'h67);
    send_byte(0, 8'h01); send_byte(1, 8'h71);
    check_state("clr"); chk("clr_lit", CURSOR, 7'h01);
    send_byte(0, 8'h85); send_byte(0, 8'h02);
    check_state("home"); chk("home_lit", CURSOR, 7'h00);

    // RS mismatch, then a timeout on the resynchronised high nibble
    send_nibble(0, 4'h4); send_nibble(1, 4'h1);
    check_state("mismatch"); chk("mismatch_err_lit", ERR, 1);
    repeat (3 * c_TIMEOUT) @(posedge CLK);
    m_timeout();
    send_byte(1, 8'h4B);
    send_byte(0, 8'h85);
    check_state("resync"); chk("resync_lit", CURSOR, 7'h05);

    // Reset between high and low nibble
    send_nibble(0, 4'h8);
    @(posedge CLK); #1 RST_N = 1'b0;
    #2;
    chk("midrst_valid", BYTE_VALID, 0);
    chk("midrst_byte", BYTE, 0);
    chk("midrst_cursor", CURSOR, 0);
    chk("midrst_mode4", MODE_4BIT, 0);
    chk("midrst_err", ERR, 0);
    m_reset();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    send_nibble(0, 4'h0);
    check_state("after_rst"); chk("after_rst_mode4_lit", MODE_4BIT, 0);

    // Timeout from a clean error state
    send_nibble(0, 4'h2);
    send_nibble(0, 4'h9);
    repeat (3 * c_TIMEOUT) @(posedge CLK);
    m_timeout();
    check_state("timeout"); chk("timeout_err_lit", ERR, 1);
    send_byte(0, 8'h85); send_byte(1, 8'h21);
    check_state("final"); chk("final_lit", CURSOR, 7'h06);

    repeat (10) @(posedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
